conv2d_stream_engine: RTL
=========================

Name: conv2d_stream_engine

Overview:
- Parametrised successor to the team's fixed 8-bit 2D convolution block.
- Loads a square filter (3x3 or 5x5) and a square image (up to MAX_IMG x MAX_IMG) over a shared input bus.
- Computes a same-size convolution with zero or replicate padding, stride 1 or 2, and ReLU or leaky activation with saturation.
- Streams results out with a valid/ready handshake. Sits between the feature-map DMA and the pooling stage.

Parameters:
- DATA_W, 8: signed input sample and coefficient width.
- OUT_W, 16: signed output width; results saturate to this width.
- MAX_IMG, 16: maximum image edge in pixels.
- LEAKY_DIV, 10: divisor applied to negative sums in leaky mode.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- filter_valid  in  1  coefficient beat valid.
- image_valid  in  1  pixel beat valid.
- filter_size  in  1  0 = 3x3, 1 = 5x5; sampled on the first filter beat.
- image_size  in  clog2(MAX_IMG+1)  image edge N; sampled on the first filter beat.
- pad_mode  in  1  0 = zero padding, 1 = replicate (edge clamp); sampled on the first filter beat.
- act_mode  in  1  0 = ReLU, 1 = leaky; sampled on the first filter beat.
- stride  in  1  0 = stride 1, 1 = stride 2; sampled on the first filter beat.
- in_data  in  DATA_W  signed coefficient or pixel.
- out_ready  in  1  downstream accepts the output beat.
- out_valid  out  1  output beat valid.
- out_data  out  OUT_W  signed activated result.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse on the clock after the last output is accepted.

Behaviour:
- Reset (async, rst_n low):
  - out_valid=0, out_data=0, busy=0, frame_done=0.
  - State IDLE; filter all zero; config = 3x3, N=MAX_IMG, zero pad, ReLU, stride 1.
- States: IDLE, FILT_IN, IMG_IN, CONV.
- IDLE:
  - filter_valid=1 -> FILT_IN. Config is latched and the filter cleared to zero in the same edge; that beat is coefficient 0.
  - Otherwise image_valid=1 -> IMG_IN. That beat is pixel 0, and the last latched config and filter are reused.
- FILT_IN:
  - Coefficients arrive row-major, k*k of them (k=3 or 5).
  - Beats beyond k*k are ignored. Missing coefficients stay zero.
  - filter_valid low -> IDLE.
- IMG_IN:
  - Pixels arrive row-major, N*N of them. Gaps (image_valid low) are allowed and the state holds.
  - The edge accepting pixel N*N-1 -> CONV. filter_valid in this state is ignored.
- N handling: N=0 or N>MAX_IMG is treated as MAX_IMG. N smaller than k is legal; the padding supplies the missing taps.
- CONV output grid:
  - Output positions are (r, c) = (i*s, j*s), with s = 1 or 2, for i, j in 0..ceil(N/s)-1, emitted row-major.
  - The kernel is centred on (r, c). Out-of-range taps read 0 (zero pad) or the clamped-coordinate pixel (replicate).
- Arithmetic:
  - Products are 2*DATA_W signed.
  - The sum is accumulated at 2*DATA_W+5 bits with no intermediate overflow.
  - Activation: sum>0 -> sum. sum<=0 and ReLU -> 0. sum<=0 and leaky -> sum/LEAKY_DIV, truncated toward zero.
  - The activated value is then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Latency: out_valid rises on the 3rd rising edge after the edge accepting the last pixel. The pipeline is tap fetch -> multiply/sum -> activate/register.
- Handshake:
  - A beat transfers on an edge where out_valid and out_ready are both 1.
  - While out_valid=1 and out_ready=0, out_data is held stable and the pipeline stalls with no loss or duplication.
  - Back-to-back beats are possible with out_ready held high (1 output/cycle).
- Completion: after the last beat transfers, frame_done pulses for one cycle, out_valid=0, and the state returns to IDLE (busy falls on the same edge).
- During CONV, filter_valid and image_valid are ignored.
- The image buffer contents are not cleared between frames. Every pixel is rewritten on each load.

Test Plan:
- Identity filter (3x3, centre=1), N=4, pixels 1..16, zero pad, stride 1, ReLU -> out 1..16 in order; first out_valid exactly 3 cycles after the last pixel; frame_done once.
- All-ones 3x3 filter, N=4 all-ones image, zero pad -> corners 4, edges 6, interior 9. Same stimulus with replicate -> all 16 outputs 9.
- Same all-ones case with stride 2 and zero pad -> exactly 4 outputs: 4, 6, 6, 9.
- Filter centre=-1, N=3 all pixels 25: leaky -> nine outputs of -2; ReLU -> nine outputs of 0.
- 5x5 filter all 127, N=5 all pixels 127, replicate -> sum 403225 -> all outputs 32767. Same case with filter all -128 and leaky -> -406400/10 = -40640 -> saturates to -32768.
- out_ready low for 5 cycles mid-frame, and 3 pixel gaps during load -> out_data stable while stalled; full 16-output sequence intact. rst_n pulsed mid-CONV -> out_valid=0 and busy=0 immediately; the next frame runs from a clean IDLE.

Source files
------------

// File: rtl/conv2d_stream_engine.sv
// Streaming 2D convolution: loads a 3x3/5x5 filter and an NxN image,
// then emits padded, strided, activated results over valid/ready.
module conv2d_stream_engine #(
  parameter int DATA_W    = 8,
  parameter int OUT_W     = 16,
  parameter int MAX_IMG   = 16,
  parameter int LEAKY_DIV = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         filter_valid,
  input  logic                         image_valid,
  input  logic                         filter_size,
  input  logic [$clog2(MAX_IMG+1)-1:0] image_size,
  input  logic                         pad_mode,
  input  logic                         act_mode,
  input  logic                         stride,
  input  logic signed [DATA_W-1:0]     in_data,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic signed [OUT_W-1:0]      out_data,
  output logic                         busy,
  output logic                         frame_done
);
  localparam int NW = $clog2(MAX_IMG+1);
  localparam int AW = $clog2(MAX_IMG);
  localparam int SW = 2*DATA_W+5;
  localparam int NT = 25;
  localparam logic signed [SW-1:0] ZERO   = '0;
  localparam logic signed [SW-1:0] SAT_HI = SW'(2**(OUT_W-1)-1);
  localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, FILT_IN, IMG_IN, CONV} state_t;
  state_t r_state, w_next;

  logic                     r_k5, r_rep, r_leaky, r_s2;
  logic [NW-1:0]            r_n;
  logic signed [DATA_W-1:0] r_filt [NT];
  logic [4:0]               r_fcnt;
  logic signed [DATA_W-1:0] r_img [MAX_IMG][MAX_IMG];
  logic [NW-1:0]            r_lr, r_lc, r_oi, r_oj;
  logic                     r_issued;
  logic signed [DATA_W-1:0] r_tap [NT];
  logic                     r_s1v, r_s1last, r_s2v, r_s2last;
  logic signed [SW-1:0]     r_sum;
  logic                     r_ov, r_olast, r_fd;
  logic signed [OUT_W-1:0]  r_out;

  logic [NW-1:0]              w_n_in, w_pr, w_pc, w_m;
  logic                       w_adv, w_xfer, w_done, w_pix;
  logic                       w_plast, w_issue, w_olast;
  logic signed [DATA_W-1:0]   w_tap [NT];
  logic signed [2*DATA_W-1:0] w_prod [NT];
  logic signed [SW-1:0]       w_sum, w_act;
  logic signed [OUT_W-1:0]    w_sat;

  assign w_n_in = (image_size == '0 || image_size > NW'(MAX_IMG))
                ? NW'(MAX_IMG) : image_size;
  assign w_adv  = !r_ov || out_ready;
  assign w_xfer = r_ov && out_ready;
  assign w_done = w_xfer && r_olast;
  assign w_pix  = image_valid &&
                  (r_state == IMG_IN ||
                   (r_state == IDLE && !filter_valid));
  assign w_pr   = (r_state == IDLE) ? '0 : r_lr;
  assign w_pc   = (r_state == IDLE) ? '0 : r_lc;
  assign w_plast = w_pix && w_pr == r_n - 1'b1 &&
                   w_pc == r_n - 1'b1;
  assign w_m    = r_s2 ? NW'(({1'b0, r_n} + 1'b1) >> 1) : r_n;
  assign w_olast = r_oi == w_m - 1'b1 && r_oj == w_m - 1'b1;
  assign w_issue = r_state == CONV && !r_issued && w_adv;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (filter_valid) w_next = FILT_IN;
        else if (image_valid) w_next = w_plast ? CONV : IMG_IN;
      end
      FILT_IN: if (!filter_valid) w_next = IDLE;
      IMG_IN:  if (w_plast) w_next = CONV;
      CONV:    if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k5    <= 1'b0;
      r_rep   <= 1'b0;
      r_leaky <= 1'b0;
      r_s2    <= 1'b0;
      r_n     <= NW'(MAX_IMG);
      r_fcnt  <= '0;
      for (int t = 0; t < NT; t++) r_filt[t] <= '0;
    end else if (r_state == IDLE && filter_valid) begin
      r_k5    <= filter_size;
      r_rep   <= pad_mode;
      r_leaky <= act_mode;
      r_s2    <= stride;
      r_n     <= w_n_in;
      for (int t = 0; t < NT; t++) r_filt[t] <= '0;
      r_filt[0] <= in_data;
      r_fcnt    <= 5'd1;
    end else if (r_state == FILT_IN && filter_valid &&
                 r_fcnt < (r_k5 ? 5'd25 : 5'd9)) begin
      r_filt[r_fcnt] <= in_data;
      r_fcnt         <= r_fcnt + 5'd1;
    end
  end

  // Pixel store is fully rewritten on every load, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_pix) r_img[w_pr[AW-1:0]][w_pc[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lr     <= '0;
      r_lc     <= '0;
      r_oi     <= '0;
      r_oj     <= '0;
      r_issued <= 1'b1;
    end else begin
      if (w_pix) begin
        if (w_pc == r_n - 1'b1) begin
          r_lc <= '0;
          r_lr <= w_pr + 1'b1;
        end else begin
          r_lc <= w_pc + 1'b1;
          r_lr <= w_pr;
        end
      end
      if (w_plast) begin
        r_oi     <= '0;
        r_oj     <= '0;
        r_issued <= 1'b0;
      end else if (w_issue) begin
        if (w_olast) r_issued <= 1'b1;
        else if (r_oj == w_m - 1'b1) begin
          r_oj <= '0;
          r_oi <= r_oi + 1'b1;
        end else r_oj <= r_oj + 1'b1;
      end
    end
  end

  // Tap t lines up with coefficient t; clamped coords serve replicate.
  always_comb begin
    int   row, col, rr, cc, n;
    logic inr;
    n   = int'(r_n);
    row = r_s2 ? 2 * int'(r_oi) : int'(r_oi);
    col = r_s2 ? 2 * int'(r_oj) : int'(r_oj);
    for (int t = 0; t < NT; t++) begin
      if (r_k5) begin
        rr = row + t / 5 - 2;
        cc = col + t % 5 - 2;
      end else begin
        rr = row + t / 3 - 1;
        cc = col + t % 3 - 1;
      end
      inr = rr >= 0 && rr < n && cc >= 0 && cc < n;
      rr  = (rr < 0) ? 0 : ((rr >= n) ? n - 1 : rr);
      cc  = (cc < 0) ? 0 : ((cc >= n) ? n - 1 : cc);
      w_tap[t] = '0;
      if ((r_k5 || t < 9) && (inr || r_rep))
        w_tap[t] = r_img[AW'(rr)][AW'(cc)];
    end
  end

  always_comb begin
    w_sum = '0;
    for (int t = 0; t < NT; t++) begin
      w_prod[t] = r_filt[t] * r_tap[t];
      w_sum     = w_sum + SW'(w_prod[t]);
    end
  end

  always_comb begin
    w_act = '0;
    if (r_sum > ZERO) w_act = r_sum;
    else if (r_leaky) w_act = r_sum / $signed(SW'(LEAKY_DIV));
    if (w_act > SAT_HI)      w_sat = OUT_W'(SAT_HI);
    else if (w_act < SAT_LO) w_sat = OUT_W'(SAT_LO);
    else                     w_sat = OUT_W'(w_act);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1v    <= 1'b0;
      r_s1last <= 1'b0;
      r_s2v    <= 1'b0;
      r_s2last <= 1'b0;
      r_sum    <= '0;
      r_ov     <= 1'b0;
      r_olast  <= 1'b0;
      r_out    <= '0;
      r_fd     <= 1'b0;
      for (int t = 0; t < NT; t++) r_tap[t] <= '0;
    end else begin
      r_fd <= w_done;
      if (w_adv) begin
        r_s1v    <= w_issue;
        r_s1last <= w_issue && w_olast;
        for (int t = 0; t < NT; t++) r_tap[t] <= w_tap[t];
        r_s2v    <= r_s1v;
        r_s2last <= r_s1last;
        r_sum    <= w_sum;
        r_ov     <= r_s2v;
        r_olast  <= r_s2last;
        if (r_s2v) r_out <= w_sat;
      end
    end
  end

  assign out_valid  = r_ov;
  assign out_data   = r_out;
  assign busy       = r_state != IDLE;
  assign frame_done = r_fd;
endmodule
